// File: rtl/color_dec_pkg.sv
// Shared mode encoding and mode-sequencing helpers for color_mode_decoder.
// COLOR_DEC_BLINK_EN adds the BLINK mode to the cycle.
package color_dec_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_ONEHOT = 2'd0,
    MODE_BINARY = 2'd1,
    MODE_BLINK  = 2'd2
  } mode_t;

  function automatic logic mode_valid(input mode_t m);
    case (m)
      MODE_ONEHOT: return 1'b1;
      MODE_BINARY: return 1'b1;
`ifdef COLOR_DEC_BLINK_EN
      MODE_BLINK:  return 1'b1;
`endif
      default:     return 1'b0;
    endcase
  endfunction

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_ONEHOT: return MODE_BINARY;
`ifdef COLOR_DEC_BLINK_EN
      MODE_BINARY: return MODE_BLINK;
`endif
      default:     return MODE_ONEHOT;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus level debouncer for the raw mode button.
// btn_rise pulses for one cycle when the debounced level goes 0 -> 1.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      // Any cycle agreeing with the held level restarts the stability count.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_rise  <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign btn_level = r_level;
  assign btn_rise  = r_rise;

endmodule

// File: rtl/color_mode_decoder.sv
// Decodes a color code onto output pins in ONEHOT / BINARY (/ BLINK) mode,
// advanced by a debounced button. Define COLOR_DEC_BLINK_EN to include BLINK.
module color_mode_decoder
  import color_dec_pkg::*;
#(
  parameter int COLOR_W         = 4,
  parameter int PIN_N           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_HALF      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COLOR_W-1:0] color,
  input  logic               mode_btn,
  output logic [PIN_N-1:0]   pins,
  output logic [MODE_W-1:0]  mode
);

  logic             w_btn_level;
  logic             w_btn_rise;
  logic             w_advance;
  mode_t            r_mode;
  mode_t            w_mode_next;
  logic [PIN_N-1:0] r_pins;
  logic [PIN_N-1:0] w_pins_next;
  logic [PIN_N-1:0] w_onehot;
  logic [PIN_N-1:0] w_binary;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (mode_btn),
    .btn_level (w_btn_level),
    .btn_rise  (w_btn_rise)
  );

  assign w_advance = w_btn_rise & w_btn_level;

  always_comb begin
    w_mode_next = r_mode;
    if (!mode_valid(r_mode)) begin
      w_mode_next = MODE_ONEHOT;
    end else if (w_advance) begin
      w_mode_next = next_mode(r_mode);
    end
  end

  // Colors at or beyond PIN_N match no bit and so light nothing.
  always_comb begin
    for (int i = 0; i < PIN_N; i++) begin
      w_onehot[i] = (color == COLOR_W'(i));
    end
  end

  if (PIN_N <= COLOR_W) begin : g_bin_trunc
    assign w_binary = color[PIN_N-1:0];
  end else begin : g_bin_ext
    assign w_binary = {{(PIN_N - COLOR_W){1'b0}}, color};
  end

`ifdef COLOR_DEC_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_HALF + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic [BLINK_W-1:0] r_blink_cnt;
  logic [BLINK_W-1:0] w_blink_cnt_next;
  logic               r_phase;
  logic               w_phase_next;

  // Entering BLINK restarts the pattern lit, so the first half-period is visible.
  always_comb begin
    w_blink_cnt_next = r_blink_cnt;
    w_phase_next     = r_phase;
    if (w_mode_next == MODE_BLINK) begin
      if (r_mode != MODE_BLINK) begin
        w_blink_cnt_next = '0;
        w_phase_next     = 1'b1;
      end else if (r_blink_cnt == BLINK_LAST) begin
        w_blink_cnt_next = '0;
        w_phase_next     = ~r_phase;
      end else begin
        w_blink_cnt_next = r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else begin
      r_blink_cnt <= w_blink_cnt_next;
      r_phase     <= w_phase_next;
    end
  end
`endif

  always_comb begin
    w_pins_next = '0;
    case (w_mode_next)
      MODE_ONEHOT: w_pins_next = w_onehot;
      MODE_BINARY: w_pins_next = w_binary;
`ifdef COLOR_DEC_BLINK_EN
      MODE_BLINK:  w_pins_next = w_phase_next ? w_onehot : '0;
`endif
      default:     w_pins_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= MODE_ONEHOT;
      r_pins <= '0;
    end else begin
      r_mode <= w_mode_next;
      r_pins <= w_pins_next;
    end
  end

  assign pins = r_pins;
  assign mode = r_mode;

endmodule

// File: tb/tb_color_mode_decoder.sv
// Self-checking bench for color_mode_decoder (COLOR_W=4, PIN_N=4, DEBOUNCE_CYCLES=4, BLINK_HALF=2).
module tb_color_mode_decoder;

  localparam int D = 4;
  localparam int H = 2;
`ifdef COLOR_DEC_BLINK_EN
  localparam int NM = 3;
`else
  localparam int NM = 2;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] color;
  logic       mode_btn;
  logic [3:0] pins;
  logic [1:0] mode;

  int errs   = 0;
  int checks = 0;

  // Reference model: button history, accepted level, run length of disagreement.
  int         m_mode, m_lvl, m_run, m_pend, m_s1, m_s2, m_age;
  logic [3:0] m_pins;

  color_mode_decoder #(
    .COLOR_W         (4),
    .PIN_N           (4),
    .DEBOUNCE_CYCLES (D),
    .BLINK_HALF      (H)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .color    (color),
    .mode_btn (mode_btn),
    .pins     (pins),
    .mode     (mode)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] onehot(input int c);
    if (c < 4) return 4'b0001 << c;
    return 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errs++;
        $error("FAIL %s: got %b expected %b", tag, got, exp);
      end
  endtask

  task automatic model_reset();
    m_mode = 0; m_lvl = 0; m_run = 0; m_pend = 0;
    m_s1 = 0; m_s2 = 0; m_age = 0; m_pins = 4'b0000;
  endtask

  task automatic model_edge();
    int nm;
    nm = (m_pend != 0) ? (m_mode + 1) % NM : m_mode;
    if (nm == 2) m_age = (m_mode != 2) ? 0 : m_age + 1;
    case (nm)
      0:       m_pins = onehot(int'(color));
      1:       m_pins = color;
      default: m_pins = ((m_age / H) % 2 == 0) ? onehot(int'(color)) : 4'b0000;
    endcase
    m_mode = nm;
    m_pend = 0;
    if (m_s2 != m_lvl) begin
      m_run++;
      if (m_run == D) begin
        m_lvl  = m_s2;
        m_run  = 0;
        m_pend = m_lvl;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = int'(mode_btn);
  endtask

  task automatic step(input logic [3:0] c, input logic b);
    color    = c;
    mode_btn = b;
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    chk("pins", pins, m_pins);
    chk("mode", {2'b00, mode}, 4'(m_mode));
  endtask

  task automatic press(input logic [3:0] c);
    repeat (8) step(c, 1'b1);
    repeat (8) step(c, 1'b0);
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst_pins", pins, 4'b0000);
    chk("async_rst_mode", {2'b00, mode}, 4'd0);
  endtask

  initial begin
    int n_on, n_off, len;
    logic b;
    reset    = 1'b1;
    color    = 4'd0;
    mode_btn = 1'b0;
    model_reset();
    step(4'd2, 1'b0);
    step(4'd2, 1'b0);
    reset = 1'b0;

    step(4'd2, 1'b0);
    chk("onehot_c2", pins, 4'b0100);
    chk("mode_after_reset", {2'b00, mode}, 4'd0);
    step(4'd5, 1'b0);
    chk("onehot_c5", pins, 4'b0000);

    repeat (2) step(4'd3, 1'b1);
    repeat (8) step(4'd3, 1'b0);
    chk("short_burst_mode", {2'b00, mode}, 4'd0);

    repeat (10) step(4'd3, 1'b1);
    repeat (8) step(4'd3, 1'b0);
    chk("hold10_mode", {2'b00, mode}, 4'd1);
    step(4'd13, 1'b0);
    chk("binary_c13", pins, 4'b1101);

`ifdef COLOR_DEC_BLINK_EN
    press(4'd1);
    chk("press_to_blink", {2'b00, mode}, 4'd2);
    n_on = 0; n_off = 0;
    for (int i = 0; i < 8; i++) begin
      step(4'd1, 1'b0);
      if (pins === 4'b0010) n_on++;
      if (pins === 4'b0000) n_off++;
    end
    chk("blink_on_count", 4'(n_on), 4'd4);
    chk("blink_off_count", 4'(n_off), 4'd4);
    press(4'd1);
    chk("press_wrap_onehot", {2'b00, mode}, 4'd0);
`else
    press(4'd1);
    chk("press_wrap_onehot", {2'b00, mode}, 4'd0);
`endif

    for (int s = 0; s < 60; s++) begin
      b   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      repeat (len) step(4'($urandom_range(0, 15)), b);
    end
    repeat (8) step(4'd0, 1'b0);

    repeat (3) step(4'd6, 1'b1);
    async_reset();
    repeat (2) step(4'd6, 1'b1);
    reset = 1'b0;
    #1;
    chk("rel_pins", pins, 4'b0000);
    chk("rel_mode", {2'b00, mode}, 4'd0);
    repeat (10) step(4'd6, 1'b1);
    chk("held_through_reset_mode", {2'b00, mode}, 4'd1);
    repeat (8) step(4'd2, 1'b0);
    chk("held_through_reset_once", {2'b00, mode}, 4'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
